// File: rtl/exc_track_pkg.sv
// Shared exception definitions for the ID/EX exception tracker and CP0.
package exc_track_pkg;

    localparam int EXC_CODE_W = 5;

    localparam logic [EXC_CODE_W-1:0] EXC_ADEL = 5'h04;
    localparam logic [EXC_CODE_W-1:0] EXC_ADES = 5'h05;
    localparam logic [EXC_CODE_W-1:0] EXC_SYS  = 5'h08;
    localparam logic [EXC_CODE_W-1:0] EXC_RI   = 5'h0a;
    localparam logic [EXC_CODE_W-1:0] EXC_OV   = 5'h0c;
    localparam logic [EXC_CODE_W-1:0] EXC_NONE = 5'h10;
    localparam logic [EXC_CODE_W-1:0] EXC_ERET = 5'h11;

    // Bit positions of each way's code inside the packed {way1, way0} bus
    localparam int EXC_CODE_WAY0_LSB = 0;
    localparam int EXC_CODE_WAY1_LSB = EXC_CODE_W;

    // Extract one way's code from the packed code bus
    function automatic logic [EXC_CODE_W-1:0] exc_code_way(
        input logic [2*EXC_CODE_W-1:0] bus,
        input logic                    way
    );
        return way ? bus[EXC_CODE_WAY1_LSB +: EXC_CODE_W]
                   : bus[EXC_CODE_WAY0_LSB +: EXC_CODE_W];
    endfunction

endpackage

// File: rtl/exc_track_if.sv
// ID/EX inputs and CP0 exception-report outputs of the exception tracker.
interface exc_track_if;
    import exc_track_pkg::*;

    logic [1:0]              id_valid;
    logic [63:0]             id_pc;
    logic [1:0]              id_if_adel;
    logic [1:0]              id_ri;
    logic [1:0]              id_sys;
    logic [1:0]              id_eret;
    logic [1:0]              id_branch;
    logic                    ex_stall;
    logic [1:0]              ex_ov;
    logic [1:0]              ex_adel;
    logic [1:0]              ex_ades;
    logic [63:0]             ex_mem_addr;
    logic                    exc_flush_all;
    logic [2*EXC_CODE_W-1:0] ex_cp0_exc_code_o;
    logic [63:0]             ex_cp0_exc_pc_o;
    logic [1:0]              ex_cp0_in_delay_o;
    logic [31:0]             ex_badaddr_o;
    logic [1:0]              ex_kill_o;

    // Exception tracker side: produces the CP0 report
    modport master (
        input  id_valid, id_pc, id_if_adel, id_ri, id_sys, id_eret, id_branch,
        input  ex_stall, ex_ov, ex_adel, ex_ades, ex_mem_addr, exc_flush_all,
        output ex_cp0_exc_code_o, ex_cp0_exc_pc_o, ex_cp0_in_delay_o,
        output ex_badaddr_o, ex_kill_o
    );

    // Pipeline/CP0 side: supplies causes and flush, consumes the report
    modport slave (
        output id_valid, id_pc, id_if_adel, id_ri, id_sys, id_eret, id_branch,
        output ex_stall, ex_ov, ex_adel, ex_ades, ex_mem_addr, exc_flush_all,
        input  ex_cp0_exc_code_o, ex_cp0_exc_pc_o, ex_cp0_in_delay_o,
        input  ex_badaddr_o, ex_kill_o
    );

endinterface

// File: rtl/exc_track_prio.sv
// Four-input priority encoder: req_i[0] is the highest priority cause.
module exc_track_prio
    import exc_track_pkg::*;
#(
    parameter logic [EXC_CODE_W-1:0] C0 = EXC_NONE,
    parameter logic [EXC_CODE_W-1:0] C1 = EXC_NONE,
    parameter logic [EXC_CODE_W-1:0] C2 = EXC_NONE,
    parameter logic [EXC_CODE_W-1:0] C3 = EXC_NONE
) (
    input  logic [3:0]            req_i,
    output logic [EXC_CODE_W-1:0] code_o
);

    // First asserted request selects the code; nothing asserted means no exception
    always_comb begin
        code_o = EXC_NONE;
        if (req_i[0])      code_o = C0;
        else if (req_i[1]) code_o = C1;
        else if (req_i[2]) code_o = C2;
        else if (req_i[3]) code_o = C3;
    end

endmodule

// File: rtl/exc_track.sv
// ID/EX exception tracker: registers ID causes, merges EX causes, tracks
// branch delay slots and drives the CP0 exception-report buses.
module exc_track #(
    parameter int EXC_CODE_W    = 5,
    parameter bit DELAY_SLOT_EN = 1'b1
) (
    input logic         clk,
    input logic         rst,
    exc_track_if.master bus
);
    import exc_track_pkg::*;

    logic [1:0]                 valid_q, valid_d;
    logic [63:0]                pc_q, pc_d;
    logic [1:0][EXC_CODE_W-1:0] code_q, code_d;
    logic [1:0]                 dly_q, dly_d;
    logic                       brp_q, brp_d;

    logic [1:0][EXC_CODE_W-1:0] id_code;
    logic [1:0][EXC_CODE_W-1:0] ex_code;
    logic [1:0][EXC_CODE_W-1:0] merged;
    logic [EXC_CODE_W-1:0]      out0, out1, sel_code;
    logic                       sel;

    for (genvar w = 0; w < 2; w++) begin : g_way
        exc_track_prio #(
            .C0(EXC_ADEL), .C1(EXC_RI), .C2(EXC_SYS), .C3(EXC_ERET)
        ) u_id_prio (
            .req_i ({bus.id_eret[w], bus.id_sys[w], bus.id_ri[w], bus.id_if_adel[w]}),
            .code_o(id_code[w])
        );

        exc_track_prio #(
            .C0(EXC_OV), .C1(EXC_ADEL), .C2(EXC_ADES), .C3(EXC_NONE)
        ) u_ex_prio (
            .req_i ({1'b0, bus.ex_ades[w], bus.ex_adel[w], bus.ex_ov[w]}),
            .code_o(ex_code[w])
        );

        // ID-stage cause wins over EX; an empty slot reports nothing
        assign merged[w] = !valid_q[w]             ? EXC_NONE :
                           (code_q[w] != EXC_NONE) ? code_q[w] : ex_code[w];
    end

    // ID/EX next state: flush beats stall, stall holds, otherwise load the bundle
    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        code_d  = code_q;
        dly_d   = dly_q;
        brp_d   = brp_q;
        if (bus.exc_flush_all) begin
            valid_d = '0;
            pc_d    = '0;
            code_d  = {2{EXC_NONE}};
            dly_d   = '0;
            brp_d   = 1'b0;
        end else if (!bus.ex_stall) begin
            valid_d = bus.id_valid;
            pc_d    = bus.id_pc;
            for (int w = 0; w < 2; w++) begin
                code_d[w] = bus.id_valid[w] ? id_code[w] : EXC_NONE;
            end
            // way0 follows a branch from an earlier bundle; way1 follows way0's branch
            dly_d[0] = brp_q & bus.id_valid[0];
            dly_d[1] = bus.id_branch[0] & bus.id_valid[0] & bus.id_valid[1];
            // A bubble must not lose a pending branch from the previous bundle
            if (|bus.id_valid) begin
                brp_d = bus.id_valid[1] ? bus.id_branch[1] : bus.id_branch[0];
            end
        end
    end

    // ID/EX register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            pc_q    <= '0;
            code_q  <= {2{EXC_NONE}};
            dly_q   <= '0;
            brp_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            code_q  <= code_d;
            dly_q   <= dly_d;
            brp_q   <= brp_d;
        end
    end

    // Way ordering, kill mask and bad-address selection for the CP0 report
    always_comb begin
        out0 = merged[0];
        out1 = (merged[0] != EXC_NONE) ? EXC_NONE : merged[1];
        bus.ex_kill_o = (out0 != EXC_NONE) ? 2'b11 : {out1 != EXC_NONE, 1'b0};
        sel      = (out0 == EXC_NONE);
        sel_code = sel ? out1 : out0;
        bus.ex_badaddr_o = '0;
        if (sel_code == EXC_ADEL && code_q[sel] == EXC_ADEL) begin
            bus.ex_badaddr_o = sel ? pc_q[63:32] : pc_q[31:0];
        end else if (sel_code == EXC_ADEL || sel_code == EXC_ADES) begin
            bus.ex_badaddr_o = sel ? bus.ex_mem_addr[63:32] : bus.ex_mem_addr[31:0];
        end
    end

    assign bus.ex_cp0_exc_code_o = {out1, out0};
    assign bus.ex_cp0_exc_pc_o   = pc_q;
    assign bus.ex_cp0_in_delay_o = DELAY_SLOT_EN ? (dly_q & valid_q) : 2'b00;

endmodule

// File: tb/tb_exc_track.sv
// Scoreboard bench for exc_track: directed bundles followed by random traffic.
module tb_exc_track;
    import exc_track_pkg::*;

    typedef struct packed {
        logic        rst;
        logic [1:0]  v;
        logic [63:0] pc;
        logic [1:0]  adel_f, ri, sys, eret, br;
        logic        stall;
        logic [1:0]  ov, adel, ades;
        logic [63:0] maddr;
        logic        flush;
    } stim_t;

    typedef struct packed {
        logic [9:0]  code;
        logic [63:0] pc;
        logic [1:0]  dly;
        logic [31:0] bad;
        logic [1:0]  kill;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    exc_track_if bus();

    exc_track dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    // Architectural view of the instruction pair sitting in EX
    bit [1:0]  m_v;
    bit [63:0] m_pc;
    bit [4:0]  m_code [2];
    bit [1:0]  m_dly;
    bit        m_pend;

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    function automatic bit rb(int n);
        return ($urandom_range(n - 1) == 0);
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s = '0;
        s.rst = rb(64);
        s.v   = 2'($urandom_range(3));
        for (int w = 0; w < 2; w++) begin
            logic [31:0] p;
            p = $urandom & 32'hffff_fffc;
            if (rb(8)) p[1:0] = 2'($urandom_range(1, 3));
            s.pc[32*w +: 32] = p;
            s.adel_f[w] = (p[1:0] != 2'b00);
            s.ri[w]     = rb(8);
            s.sys[w]    = rb(8);
            s.eret[w]   = rb(8);
            s.br[w]     = rb(4);
            s.ov[w]     = rb(8);
            s.adel[w]   = rb(8);
            s.ades[w]   = rb(8);
        end
        s.maddr = {$urandom, $urandom};
        s.stall = rb(8);
        s.flush = rb(16);
        return s;
    endfunction

    function automatic bit [4:0] id_cause(stim_t s, int w);
        if (s.adel_f[w]) return EXC_ADEL;
        if (s.ri[w])     return EXC_RI;
        if (s.sys[w])    return EXC_SYS;
        if (s.eret[w])   return EXC_ERET;
        return EXC_NONE;
    endfunction

    // What CP0 should see this cycle, given the pair in EX and this cycle's EX flags
    function automatic exp_t predict(stim_t s);
        exp_t     e;
        bit [4:0] c [2];
        int       first;
        for (int w = 0; w < 2; w++) begin
            if (!m_v[w])                c[w] = EXC_NONE;
            else if (m_code[w] != EXC_NONE) c[w] = m_code[w];
            else if (s.ov[w])           c[w] = EXC_OV;
            else if (s.adel[w])         c[w] = EXC_ADEL;
            else if (s.ades[w])         c[w] = EXC_ADES;
            else                        c[w] = EXC_NONE;
        end
        if (c[0] != EXC_NONE) begin
            c[1]   = EXC_NONE;
            e.kill = 2'b11;
            first  = 0;
        end else begin
            e.kill = {c[1] != EXC_NONE, 1'b0};
            first  = (c[1] != EXC_NONE) ? 1 : -1;
        end
        e.bad = '0;
        if (first >= 0) begin
            if (c[first] == EXC_ADEL && m_code[first] == EXC_ADEL)
                e.bad = m_pc[32*first +: 32];
            else if (c[first] == EXC_ADEL || c[first] == EXC_ADES)
                e.bad = s.maddr[32*first +: 32];
        end
        e.code = {c[1], c[0]};
        e.pc   = m_pc;
        e.dly  = m_dly & m_v;
        return e;
    endfunction

    task automatic model_clear();
        m_v = '0; m_pc = '0; m_code[0] = EXC_NONE; m_code[1] = EXC_NONE;
        m_dly = '0; m_pend = 1'b0;
    endtask

    // Advance the model by one clock edge
    task automatic model_step(stim_t s);
        if (s.rst || s.flush) begin
            model_clear();
        end else if (!s.stall) begin
            m_dly[0] = m_pend & s.v[0];
            m_dly[1] = s.br[0] & s.v[0] & s.v[1];
            if (s.v != 2'b00) m_pend = s.v[1] ? s.br[1] : s.br[0];
            m_v  = s.v;
            m_pc = s.pc;
            for (int w = 0; w < 2; w++) m_code[w] = s.v[w] ? id_cause(s, w) : EXC_NONE;
        end
    endtask

    task automatic drive(stim_t s);
        rst                = s.rst;
        bus.id_valid       = s.v;
        bus.id_pc          = s.pc;
        bus.id_if_adel     = s.adel_f;
        bus.id_ri          = s.ri;
        bus.id_sys         = s.sys;
        bus.id_eret        = s.eret;
        bus.id_branch      = s.br;
        bus.ex_stall       = s.stall;
        bus.ex_ov          = s.ov;
        bus.ex_adel        = s.adel;
        bus.ex_ades        = s.ades;
        bus.ex_mem_addr    = s.maddr;
        bus.exc_flush_all  = s.flush;
    endtask

    // One cycle: drive inputs, queue the expected report, step the model, advance
    task automatic apply(stim_t s);
        drive(s);
        exp_q.push_back(predict(s));
        model_step(s);
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h, expected %h", nm, cyc, act, req);
        end
    endtask

    // Monitor: compares the DUT report against the oldest queued expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("code",   64'(bus.ex_cp0_exc_code_o), 64'(e.code));
                chk("pc",     bus.ex_cp0_exc_pc_o,        e.pc);
                chk("dly",    64'(bus.ex_cp0_in_delay_o), 64'(e.dly));
                chk("bad",    64'(bus.ex_badaddr_o),      64'(e.bad));
                chk("kill",   64'(bus.ex_kill_o),         64'(e.kill));
            end
        end
    end

    initial begin
        stim_t s;
        s = rand_stim();
        s.rst = 1'b1;
        drive(s);
        @(posedge clk);
        #1;
        model_clear();

        // Reset held with busy inputs
        for (int i = 0; i < 2; i++) begin
            s = rand_stim();
            s.rst = 1'b1;
            apply(s);
        end

        // SYSCALL on way0 masks RI on way1
        s = idle(); s.v = 2'b11; s.pc = {32'h104, 32'h100}; s.sys = 2'b01; s.ri = 2'b10; apply(s);
        s = idle(); apply(s);

        // Way1 branch, next bundle way0 is in the delay slot and overflows
        s = idle(); s.v = 2'b11; s.pc = {32'h204, 32'h200}; s.br = 2'b10; apply(s);
        s = idle(); s.v = 2'b01; s.pc = {32'h0, 32'h208}; apply(s);
        s = idle(); s.ov = 2'b01; apply(s);

        // Same with a bubble between the bundles
        s = idle(); s.v = 2'b11; s.pc = {32'h204, 32'h200}; s.br = 2'b10; apply(s);
        s = idle(); apply(s);
        s = idle(); s.v = 2'b01; s.pc = {32'h0, 32'h208}; apply(s);
        s = idle(); s.ov = 2'b01; apply(s);

        // Way0 branch, way1 delay slot with a misaligned store
        s = idle(); s.v = 2'b11; s.pc = {32'h404, 32'h400}; s.br = 2'b01; apply(s);
        s = idle(); s.ades = 2'b10; s.maddr = {32'h1003, 32'h0}; apply(s);

        // Flush and stall together while a branch is pending
        s = idle(); s.v = 2'b01; s.pc = {32'h0, 32'h500}; s.br = 2'b01; apply(s);
        s = idle(); s.flush = 1'b1; s.stall = 1'b1; apply(s);
        s = idle(); s.v = 2'b01; s.pc = {32'h0, 32'h508}; apply(s);
        s = idle(); apply(s);

        // Fetch misalignment beats EX load misalignment on the same way
        s = idle(); s.v = 2'b01; s.pc = {32'h0, 32'h302}; s.adel_f = 2'b01; apply(s);
        s = idle(); s.adel = 2'b01; s.maddr = {32'h0, 32'hdead_beef}; apply(s);
        s = idle(); apply(s);

        // Random traffic
        for (int i = 0; i < 500; i++) apply(rand_stim());

        repeat (3) @(negedge clk);
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
